// File: rtl/router_out_reader.sv
// Output-port reader: pops the router FIFO into a 3-entry skid buffer, parses packet
// framing (header/payload/parity) on the way in, and flags errors, aborts and starvation.
module router_out_reader #(
  parameter logic [1:0] PORT_ID    = 2'd0,
  parameter logic [4:0] STALL_WARN = 5'd28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  output logic       read_enb,
  input  logic       pkt_ready,
  output logic       pkt_valid,
  output logic [7:0] pkt_data,
  output logic       pkt_sop,
  output logic       pkt_eop,
  output logic       pkt_perr,
  output logic       addr_err,
  output logic       pkt_abort,
  output logic       starve_warn,
  output logic [7:0] pkt_count
);

  typedef enum logic [1:0] {S_HDR = 2'd0, S_PAYLOAD = 2'd1, S_PARITY = 2'd2} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       perr;
  } entry_t;

  state_t     state_q;
  logic [5:0] len_rem_q;
  logic [7:0] par_q;
  logic       rd_pend_q;
  logic [1:0] occ_q, wr_ptr_q, rd_ptr_q;
  entry_t     buf_q [3];
  logic [4:0] stall_q;
  logic       addr_err_q, pkt_abort_q;
  logic [7:0] pkt_count_q;

  logic       push, pop, room;
  logic [1:0] occ_d, wr_ptr_d, rd_ptr_d;
  entry_t     new_entry, head;

  // The byte requested last cycle is on data_out now; room counts it as already taken.
  assign push     = rd_pend_q;
  assign pop      = (occ_q != 2'd0) && pkt_ready;
  assign room     = ({1'b0, occ_q} + {2'b00, rd_pend_q}) < 3'd3;
  assign read_enb = ~reset & vld_out & ~soft_reset & room;

  always_comb begin
    new_entry = '{data: data_out, sop: 1'b0, eop: 1'b0, perr: 1'b0};
    case (state_q)
      S_HDR:    new_entry.sop = 1'b1;
      S_PARITY: begin
        new_entry.eop  = 1'b1;
        new_entry.perr = (data_out != par_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: ;
    endcase
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
  end

  assign head        = buf_q[rd_ptr_q];
  assign pkt_valid   = (occ_q != 2'd0);
  assign pkt_data    = head.data;
  assign pkt_sop     = pkt_valid & head.sop;
  assign pkt_eop     = pkt_valid & head.eop;
  assign pkt_perr    = pkt_valid & head.perr;
  assign addr_err    = addr_err_q;
  assign pkt_abort   = pkt_abort_q;
  assign starve_warn = (stall_q >= STALL_WARN);
  assign pkt_count   = pkt_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HDR;
      len_rem_q   <= 6'd0;
      par_q       <= 8'd0;
      rd_pend_q   <= 1'b0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      stall_q     <= 5'd0;
      addr_err_q  <= 1'b0;
      pkt_abort_q <= 1'b0;
      pkt_count_q <= 8'd0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      addr_err_q  <= 1'b0;
      pkt_abort_q <= 1'b0;
      if (vld_out && !read_enb)
        stall_q <= (stall_q == 5'd31) ? stall_q : stall_q + 5'd1;
      else
        stall_q <= 5'd0;

      if (soft_reset) begin
        // Flush wins over any push/pop on this edge; the in-flight byte is dropped.
        pkt_abort_q <= (state_q != S_HDR) || (occ_q != 2'd0);
        state_q     <= S_HDR;
        len_rem_q   <= 6'd0;
        par_q       <= 8'd0;
        rd_pend_q   <= 1'b0;
        occ_q       <= 2'd0;
        wr_ptr_q    <= 2'd0;
        rd_ptr_q    <= 2'd0;
      end else begin
        rd_pend_q <= read_enb;
        occ_q     <= occ_d;
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        if (push) begin
          buf_q[wr_ptr_q] <= new_entry;
          case (state_q)
            S_HDR: begin
              len_rem_q  <= data_out[7:2];
              par_q      <= data_out;
              addr_err_q <= (data_out[1:0] != PORT_ID);
              state_q    <= (data_out[7:2] != 6'd0) ? S_PAYLOAD : S_PARITY;
            end
            S_PAYLOAD: begin
              par_q     <= par_q ^ data_out;
              len_rem_q <= len_rem_q - 6'd1;
              if (len_rem_q == 6'd1) state_q <= S_PARITY;
            end
            S_PARITY: begin
              pkt_count_q <= pkt_count_q + 8'd1;
              state_q     <= S_HDR;
            end
            default: state_q <= S_HDR;
          endcase
        end
      end
    end
  end

endmodule
